run_length_detector: RTL and testbench

//   Parametrised consecutive-ones detector for a qualified serial bit stream.

---
 rtl/run_length_detector.sv | 122 ++++++++++++
 tb/tb_run_length_detector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_length_detector.sv
// run_length_detector
//   Consecutive-ones detector for a qualified serial bit stream. It counts
//   back-to-back valid '1' samples and pulses detect for one cycle when the
//   run reaches THRESHOLD. OVERLAP selects restart-after-hit (0) or a sliding
//   window that fires again on every further '1' (1).
//
//   Optional feature macro: RLD_STATS_EN adds the hit_total port and a
//   16-bit saturating hit counter.
//
// Parameters
//   CNT_W      run counter width; THRESHOLD must lie in 1..2**CNT_W-1
//   THRESHOLD  run length that fires detect
//   OVERLAP    0: restart after a hit, 1: saturate at THRESHOLD and re-fire
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   clear      synchronous soft clear of run state (hit_total untouched)
//   bit_valid  qualifies bit_in
//   bit_in     serial data bit
//   count      current run length (registered)
//   detect     one-cycle hit pulse (registered)
//   state      debug state: 00 IDLE, 01 RUN, 10 HIT
//   hit_total  saturating hit counter (RLD_STATS_EN only)
module run_length_detector #(
  parameter int CNT_W     = 4,
  parameter int THRESHOLD = 3,
  parameter int OVERLAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count,
  output logic             detect,
  output logic [1:0]       state
`ifdef RLD_STATS_EN
  ,
  output logic [15:0]      hit_total
`endif
);

  if (THRESHOLD < 1 || THRESHOLD > (2**CNT_W) - 1) begin : g_bad_threshold
    $error("run_length_detector: THRESHOLD out of range 1..2**CNT_W-1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_d;
  logic               detect_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count   <= '0;
      detect  <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      detect  <= detect_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count;
    detect_d = 1'b0;
    if (clear) begin
      // clear wins over a coincident sample; the sample is dropped
      state_d = IDLE;
      count_d = '0;
    end else if (bit_valid) begin
      if (!bit_in) begin
        state_d = IDLE;
        count_d = '0;
      end else if (state_q == RUN) begin
        // count < THRESHOLD here, so the increment cannot overflow
        count_d = count + ONE;
        if (count + ONE == THR) begin
          state_d  = HIT;
          detect_d = 1'b1;
        end
      end else if (state_q == HIT && OVERLAP != 0) begin
        // sliding window: hold count at THRESHOLD and fire again
        count_d  = THR;
        detect_d = 1'b1;
      end else begin
        // IDLE, HIT without overlap, or the unused encoding: fresh run
        count_d = ONE;
        if (THRESHOLD == 1) begin
          state_d  = HIT;
          detect_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
    end
  end

  assign state = state_q;

`ifdef RLD_STATS_EN
  // Steps on the same edge that raises detect, so hit_total already
  // includes the pulse currently visible on detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_total <= '0;
    end else if (detect_d && hit_total != 16'hFFFF) begin
      hit_total <= hit_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: four instances with different
// THRESHOLD/OVERLAP settings share one stimulus stream and are compared
// against a run-length model (count derived from the length of the current
// unbroken run of valid ones).
module tb_run_length_detector;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int THR_P [N] = '{3, 3, 1, 15};
  localparam int OVL_P [N] = '{0, 1, 1, 0};

  logic clk = 1'b0;
  logic rst = 1'b1, clear = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
  logic [CW-1:0] cnt [N];
  logic          det [N];
  logic [1:0]    st  [N];
`ifdef RLD_STATS_EN
  logic [15:0]   ht  [N];
`endif

  int checks = 0;
  int errors = 0;

  // model state: length of the current unbroken run of sampled ones
  int run  [N] = '{0, 0, 0, 0};
  int hits [N] = '{0, 0, 0, 0};
  bit edet [N] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    run_length_detector #(.CNT_W(CW), .THRESHOLD(THR_P[g]), .OVERLAP(OVL_P[g])) dut (
      .clk(clk), .rst(rst), .clear(clear), .bit_valid(bit_valid), .bit_in(bit_in),
      .count(cnt[g]), .detect(det[g]), .state(st[g])
`ifdef RLD_STATS_EN
      , .hit_total(ht[g])
`endif
    );
  end

  function automatic int exp_cnt(input int i);
    if (run[i] == 0) return 0;
    if (OVL_P[i] != 0) return (run[i] < THR_P[i]) ? run[i] : THR_P[i];
    return ((run[i] - 1) % THR_P[i]) + 1;
  endfunction

  function automatic int exp_st(input int i);
    if (run[i] == 0) return 0;
    return (exp_cnt(i) == THR_P[i]) ? 2 : 1;
  endfunction

  // drive one cycle, advance the model at the edge, return at negedge
  task automatic cyc(input bit r, input bit c, input bit v, input bit b);
    rst = r; clear = c; bit_valid = v; bit_in = b;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      edet[i] = 1'b0;
      if (r) begin
        run[i] = 0; hits[i] = 0;
      end else if (c) begin
        run[i] = 0;
      end else if (v) begin
        if (b) begin
          run[i]++;
          edet[i] = (OVL_P[i] != 0) ? (run[i] >= THR_P[i]) : (run[i] % THR_P[i] == 0);
          if (edet[i] && hits[i] < 65535) hits[i]++;
        end else begin
          run[i] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(1, 0, 1, 1);
    cyc(1, 1, 1, 1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt[i] !== 4'd0 || det[i] !== 1'b0 || st[i] !== 2'b00) begin
        errors++;
        $display("FAIL reset dut%0d: cnt=%0d det=%0b st=%0d want 0/0/0", i, cnt[i], det[i], st[i]);
      end
`ifdef RLD_STATS_EN
      checks++;
      if (ht[i] !== 16'd0) begin
        errors++;
        $display("FAIL reset_hit_total dut%0d: got %0d want 0", i, ht[i]);
      end
`endif
    end
  endtask

  task automatic test_basic();
    int ec [3] = '{1, 2, 3};
    int es [3] = '{1, 1, 2};
    int ed [3] = '{0, 0, 1};
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 1);
      checks++;
      if (cnt[0] !== ec[k][CW-1:0] || st[0] !== es[k][1:0] || det[0] !== ed[k][0]) begin
        errors++;
        $display("FAIL basic step%0d: cnt=%0d st=%0d det=%0b want %0d/%0d/%0d",
                 k, cnt[0], st[0], det[0], ec[k], es[k], ed[k]);
      end
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (det[0] !== 1'b0 || cnt[0] !== 4'd3) begin
      errors++;
      $display("FAIL basic_pulse_width: det=%0b cnt=%0d want 0/3", det[0], cnt[0]);
    end
  endtask

  task automatic test_overlap();
    int n0 = 0, n1 = 0;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 1, 1);
      n0 += int'(det[0]);
      n1 += int'(det[1]);
    end
    checks++;
    if (n0 != 2) begin errors++; $display("FAIL overlap0_pulses: got %0d want 2", n0); end
    checks++;
    if (n1 != 4) begin errors++; $display("FAIL overlap1_pulses: got %0d want 4", n1); end
    checks++;
    if (cnt[1] !== 4'd3) begin errors++; $display("FAIL overlap1_count: got %0d want 3", cnt[1]); end
  endtask

  task automatic test_break();
    bit seq [5] = '{1, 1, 0, 1, 1};
    int nd = 0;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1, seq[k]);
      nd += int'(det[0]);
      if (k == 2) begin
        checks++;
        if (cnt[0] !== 4'd0 || st[0] !== 2'b00) begin
          errors++;
          $display("FAIL break_after_zero: cnt=%0d st=%0d want 0/0", cnt[0], st[0]);
        end
      end
    end
    checks++;
    if (nd != 0 || cnt[0] !== 4'd2) begin
      errors++;
      $display("FAIL break_no_detect: pulses=%0d cnt=%0d want 0/2", nd, cnt[0]);
    end
  endtask

  task automatic test_gaps();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 1'($urandom_range(0, 1)));
      checks++;
      if (cnt[0] !== 4'd1 || det[0] !== 1'b0 || st[0] !== 2'b01) begin
        errors++;
        $display("FAIL gap_hold%0d: cnt=%0d det=%0b st=%0d want 1/0/1", k, cnt[0], det[0], st[0]);
      end
    end
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    checks++;
    if (det[0] !== 1'b1 || cnt[0] !== 4'd3 || st[0] !== 2'b10) begin
      errors++;
      $display("FAIL gap_detect: det=%0b cnt=%0d st=%0d want 1/3/2", det[0], cnt[0], st[0]);
    end
  endtask

  task automatic test_clear_rst();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    checks++;
    if (cnt[0] !== 4'd0 || det[0] !== 1'b0 || st[0] !== 2'b00) begin
      errors++;
      $display("FAIL clear: cnt=%0d det=%0b st=%0d want 0/0/0", cnt[0], det[0], st[0]);
    end
    cyc(0, 0, 1, 1);
    checks++;
    if (cnt[0] !== 4'd1 || det[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_fresh_run: cnt=%0d det=%0b want 1/0", cnt[0], det[0]);
    end
    cyc(0, 0, 1, 1);
    cyc(1, 0, 1, 1);
    checks++;
    if (cnt[0] !== 4'd0 || det[0] !== 1'b0 || st[0] !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_run: cnt=%0d det=%0b st=%0d want 0/0/0", cnt[0], det[0], st[0]);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (det[0] !== 1'b0) begin errors++; $display("FAIL rst_no_late_detect: det=%0b want 0", det[0]); end
  endtask

  task automatic test_random();
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (cnt[i] !== CW'(exp_cnt(i))) begin
          errors++;
          $display("FAIL rand_count dut%0d cyc%0d: got %0d want %0d", i, k, cnt[i], exp_cnt(i));
        end
        checks++;
        if (det[i] !== edet[i]) begin
          errors++;
          $display("FAIL rand_detect dut%0d cyc%0d: got %0b want %0b", i, k, det[i], edet[i]);
        end
        checks++;
        if (st[i] !== 2'(exp_st(i))) begin
          errors++;
          $display("FAIL rand_state dut%0d cyc%0d: got %0d want %0d", i, k, st[i], exp_st(i));
        end
`ifdef RLD_STATS_EN
        checks++;
        if (ht[i] !== 16'(hits[i])) begin
          errors++;
          $display("FAIL rand_hit_total dut%0d cyc%0d: got %0d want %0d", i, k, ht[i], hits[i]);
        end
`endif
      end
    end
  endtask

`ifdef RLD_STATS_EN
  task automatic test_stats();
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 70000; k++) cyc(0, 0, 1, 1);
    checks++;
    if (ht[2] !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_saturate: got %h want ffff", ht[2]);
    end
    checks++;
    if (ht[0] !== 16'(hits[0])) begin
      errors++;
      $display("FAIL stats_thr3: got %0d want %0d", ht[0], hits[0]);
    end
    cyc(0, 1, 1, 1);
    checks++;
    if (ht[2] !== 16'hFFFF || cnt[2] !== 4'd0) begin
      errors++;
      $display("FAIL stats_clear: ht=%h cnt=%0d want ffff/0", ht[2], cnt[2]);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (ht[2] !== 16'd0) begin
      errors++;
      $display("FAIL stats_rst: got %h want 0", ht[2]);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_overlap();
    test_break();
    test_gaps();
    test_clear_rst();
    test_random();
`ifdef RLD_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
